// File: rtl/axi_lite_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_arbiter_if
//  Purpose  : One AXI-Lite bus (AW, W, B, AR and R channels) as a bundle.
//             Used for both the requester ports and the shared master port
//             of axi_lite_arbiter.
//  Modports : master - drives AW/W/AR payload and valids, plus bready/rready
//             slave  - drives the ready signals and the B/R responses
//  Revision : 1.0 - initial release
// ============================================================================
interface axi_lite_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [RESP_WIDTH-1:0]   bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [RESP_WIDTH-1:0]   rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_arbiter
//  Purpose  : Shares one AXI-Lite master port between two requesters with
//             round-robin arbitration and a single transaction in flight.
//             Within a granted port a write wins over a read.
//  Ports    : axi_aclk   - clock, rising edge
//             axi_areset - synchronous active-high reset
//             s0_axi     - requester 0 (arbiter acts as AXI slave)
//             s1_axi     - requester 1 (arbiter acts as AXI slave)
//             m_axi      - shared downstream AXI-Lite master port
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3
) (
    input  logic               axi_aclk,
    input  logic               axi_areset,
    axi_lite_arbiter_if.slave  s0_axi,
    axi_lite_arbiter_if.slave  s1_axi,
    axi_lite_arbiter_if.master m_axi
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W_ISSUE = 3'd1,
        S_W_RESP  = 3'd2,
        S_W_RET   = 3'd3,
        S_R_ISSUE = 3'd4,
        S_R_RESP  = 3'd5,
        S_R_RET   = 3'd6
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_last_grant;
    logic                    r_owner;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic [RESP_WIDTH-1:0]   r_resp;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_aw_done;
    logic                    r_w_done;

    logic w_wr_req0, w_wr_req1, w_req0, w_req1;
    logic w_idle, w_grant0, w_grant1, w_grant_wr;
    logic w_m_awvalid, w_m_wvalid, w_m_arvalid, w_m_bready, w_m_rready;
    logic w_ret_bvalid, w_ret_rvalid, w_owner_bready, w_owner_rready;

    assign w_wr_req0 = s0_axi.awvalid & s0_axi.wvalid;
    assign w_wr_req1 = s1_axi.awvalid & s1_axi.wvalid;
    assign w_req0    = w_wr_req0 | s0_axi.arvalid;
    assign w_req1    = w_wr_req1 | s1_axi.arvalid;

    // Grants are suppressed while reset is high so no ready leaks out of
    // a cycle whose state update is about to be discarded.
    assign w_idle     = (r_state == S_IDLE) && !axi_areset;
    assign w_grant0   = w_idle && w_req0 && (!w_req1 || r_last_grant);
    assign w_grant1   = w_idle && w_req1 && (!w_req0 || !r_last_grant);
    assign w_grant_wr = w_grant1 ? w_wr_req1 : w_wr_req0;

    assign w_owner_bready = r_owner ? s1_axi.bready : s0_axi.bready;
    assign w_owner_rready = r_owner ? s1_axi.rready : s0_axi.rready;

    always_comb begin
        w_next_state = r_state;
        w_m_awvalid  = 1'b0;
        w_m_wvalid   = 1'b0;
        w_m_arvalid  = 1'b0;
        w_m_bready   = 1'b0;
        w_m_rready   = 1'b0;
        w_ret_bvalid = 1'b0;
        w_ret_rvalid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant0 || w_grant1) begin
                    w_next_state = w_grant_wr ? S_W_ISSUE : S_R_ISSUE;
                end
            end
            S_W_ISSUE: begin
                // AW and W complete independently; leave once both are done.
                w_m_awvalid = !r_aw_done;
                w_m_wvalid  = !r_w_done;
                if ((r_aw_done || m_axi.awready) && (r_w_done || m_axi.wready)) begin
                    w_next_state = S_W_RESP;
                end
            end
            S_W_RESP: begin
                w_m_bready = 1'b1;
                if (m_axi.bvalid) begin
                    w_next_state = S_W_RET;
                end
            end
            S_W_RET: begin
                w_ret_bvalid = 1'b1;
                if (w_owner_bready) begin
                    w_next_state = S_IDLE;
                end
            end
            S_R_ISSUE: begin
                w_m_arvalid = 1'b1;
                if (m_axi.arready) begin
                    w_next_state = S_R_RESP;
                end
            end
            S_R_RESP: begin
                w_m_rready = 1'b1;
                if (m_axi.rvalid) begin
                    w_next_state = S_R_RET;
                end
            end
            S_R_RET: begin
                w_ret_rvalid = 1'b1;
                if (w_owner_rready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_resp       <= '0;
            r_rdata      <= '0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    if (w_grant0 || w_grant1) begin
                        r_owner      <= w_grant1;
                        r_last_grant <= w_grant1;
                        if (w_grant_wr) begin
                            r_addr  <= w_grant1 ? s1_axi.awaddr : s0_axi.awaddr;
                            r_wdata <= w_grant1 ? s1_axi.wdata  : s0_axi.wdata;
                            r_wstrb <= w_grant1 ? s1_axi.wstrb  : s0_axi.wstrb;
                        end else begin
                            r_addr  <= w_grant1 ? s1_axi.araddr : s0_axi.araddr;
                        end
                    end
                end
                S_W_ISSUE: begin
                    if (w_m_awvalid && m_axi.awready) r_aw_done <= 1'b1;
                    if (w_m_wvalid && m_axi.wready)   r_w_done  <= 1'b1;
                end
                S_W_RESP: begin
                    if (m_axi.bvalid) r_resp <= m_axi.bresp;
                end
                S_R_RESP: begin
                    if (m_axi.rvalid) begin
                        r_resp  <= m_axi.rresp;
                        r_rdata <= m_axi.rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Master port: payload straight from the capture registers, so it is
    // stable for as long as the corresponding valid waits for ready.
    assign m_axi.awaddr  = r_addr;
    assign m_axi.araddr  = r_addr;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = r_wstrb;
    assign m_axi.awvalid = w_m_awvalid;
    assign m_axi.wvalid  = w_m_wvalid;
    assign m_axi.arvalid = w_m_arvalid;
    assign m_axi.bready  = w_m_bready;
    assign m_axi.rready  = w_m_rready;

    // Requester ports: ready only in the grant cycle, responses only to the
    // owner; everything else reads as zero.
    assign s0_axi.awready = w_grant0 && w_wr_req0;
    assign s0_axi.wready  = w_grant0 && w_wr_req0;
    assign s0_axi.arready = w_grant0 && !w_wr_req0;
    assign s1_axi.awready = w_grant1 && w_wr_req1;
    assign s1_axi.wready  = w_grant1 && w_wr_req1;
    assign s1_axi.arready = w_grant1 && !w_wr_req1;

    assign s0_axi.bvalid = w_ret_bvalid && !r_owner;
    assign s0_axi.bresp  = (w_ret_bvalid && !r_owner) ? r_resp : '0;
    assign s0_axi.rvalid = w_ret_rvalid && !r_owner;
    assign s0_axi.rresp  = (w_ret_rvalid && !r_owner) ? r_resp : '0;
    assign s0_axi.rdata  = (w_ret_rvalid && !r_owner) ? r_rdata : '0;
    assign s1_axi.bvalid = w_ret_bvalid && r_owner;
    assign s1_axi.bresp  = (w_ret_bvalid && r_owner) ? r_resp : '0;
    assign s1_axi.rvalid = w_ret_rvalid && r_owner;
    assign s1_axi.rresp  = (w_ret_rvalid && r_owner) ? r_resp : '0;
    assign s1_axi.rdata  = (w_ret_rvalid && r_owner) ? r_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_arbiter
//  Purpose  : Self-checking bench for axi_lite_arbiter. Requester tasks drive
//             the two ports, a small responder model plays the downstream
//             slave, and scoreboard queues hold the expected master-side
//             requests and requester-side responses.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axi_lite_arbiter;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) s0_axi ();
    axi_lite_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) s1_axi ();
    axi_lite_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) m_axi ();

    axi_lite_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) dut (
        .axi_aclk   (clk),
        .axi_areset (rst),
        .s0_axi     (s0_axi),
        .s1_axi     (s1_axi),
        .m_axi      (m_axi)
    );

    // ---------------- requester drive / observe ----------------
    logic [AW-1:0]   awaddr_d [2];
    logic [DW-1:0]   wdata_d  [2];
    logic [DW/8-1:0] wstrb_d  [2];
    logic [AW-1:0]   araddr_d [2];
    logic [1:0]      awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d;

    assign s0_axi.awaddr = awaddr_d[0];  assign s1_axi.awaddr = awaddr_d[1];
    assign s0_axi.wdata  = wdata_d[0];   assign s1_axi.wdata  = wdata_d[1];
    assign s0_axi.wstrb  = wstrb_d[0];   assign s1_axi.wstrb  = wstrb_d[1];
    assign s0_axi.araddr = araddr_d[0];  assign s1_axi.araddr = araddr_d[1];
    assign s0_axi.awvalid = awvalid_d[0]; assign s1_axi.awvalid = awvalid_d[1];
    assign s0_axi.wvalid  = wvalid_d[0];  assign s1_axi.wvalid  = wvalid_d[1];
    assign s0_axi.arvalid = arvalid_d[0]; assign s1_axi.arvalid = arvalid_d[1];
    assign s0_axi.bready  = bready_d[0];  assign s1_axi.bready  = bready_d[1];
    assign s0_axi.rready  = rready_d[0];  assign s1_axi.rready  = rready_d[1];

    logic [1:0]    awready_s, wready_s, arready_s, bvalid_s, rvalid_s;
    logic [RW-1:0] bresp_s [2];
    logic [RW-1:0] rresp_s [2];
    logic [DW-1:0] rdata_s [2];
    assign awready_s = {s1_axi.awready, s0_axi.awready};
    assign wready_s  = {s1_axi.wready,  s0_axi.wready};
    assign arready_s = {s1_axi.arready, s0_axi.arready};
    assign bvalid_s  = {s1_axi.bvalid,  s0_axi.bvalid};
    assign rvalid_s  = {s1_axi.rvalid,  s0_axi.rvalid};
    assign bresp_s[0] = s0_axi.bresp;  assign bresp_s[1] = s1_axi.bresp;
    assign rresp_s[0] = s0_axi.rresp;  assign rresp_s[1] = s1_axi.rresp;
    assign rdata_s[0] = s0_axi.rdata;  assign rdata_s[1] = s1_axi.rdata;

    // ---------------- downstream responder model ----------------
    int            aw_stall = 0;
    int            aw_wait  = 0;
    logic [RW-1:0] bresp_m  = '0;
    logic [DW-1:0] rdata_m  = '0;
    logic [RW-1:0] rresp_m  = '0;
    logic          r_hold   = 1'b0;

    assign m_axi.awready = (aw_wait >= aw_stall);
    assign m_axi.wready  = 1'b1;
    assign m_axi.arready = 1'b1;
    assign m_axi.bvalid  = m_axi.bready;
    assign m_axi.bresp   = bresp_m;
    assign m_axi.rvalid  = m_axi.rready && !r_hold;
    assign m_axi.rdata   = rdata_m;
    assign m_axi.rresp   = rresp_m;

    always @(posedge clk) begin
        if (m_axi.awvalid && !m_axi.awready) aw_wait <= aw_wait + 1;
        else                                 aw_wait <= 0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        int            port;
        bit            is_wr;
        logic [DW-1:0] data;
        logic [RW-1:0] resp;
    } rsp_t;

    typedef struct {
        bit              is_wr;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
    } mreq_t;

    rsp_t  rsp_q  [$];
    mreq_t mreq_q [$];

    function automatic rsp_t mk_rsp(int p, bit w, logic [DW-1:0] d, logic [RW-1:0] r);
        rsp_t e;
        e.port = p; e.is_wr = w; e.data = d; e.resp = r;
        return e;
    endfunction

    function automatic mreq_t mk_req(bit w, logic [AW-1:0] a, logic [DW-1:0] d, logic [DW/8-1:0] s);
        mreq_t e;
        e.is_wr = w; e.addr = a; e.data = d; e.strb = s;
        return e;
    endfunction

    // ---------------- monitors ----------------
    logic          awhs, whs, arhs;
    logic          aw_seen = 1'b0, w_seen = 1'b0;
    logic          prev_aw_pend = 1'b0;
    logic [AW-1:0] prev_awaddr = '0;
    int            aw_cyc = 0, w_cyc = 0, t_aw = 0;
    int            t_grant [2];
    int            t_ret   [2];

    assign awhs = m_axi.awvalid && m_axi.awready;
    assign whs  = m_axi.wvalid  && m_axi.wready;
    assign arhs = m_axi.arvalid && m_axi.arready;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_aw_pend) begin
                check("awvalid_hold", m_axi.awvalid, 1);
                check("awaddr_stable", m_axi.awaddr, prev_awaddr);
            end
            prev_aw_pend <= m_axi.awvalid && !m_axi.awready;
            prev_awaddr  <= m_axi.awaddr;
            if (m_axi.awvalid) aw_cyc <= aw_cyc + 1;
            if (m_axi.wvalid)  w_cyc  <= w_cyc + 1;

            if (awhs || whs || arhs) begin
                if (mreq_q.size() == 0) begin
                    check("mreq_pending", mreq_q.size(), 1);
                end else begin
                    if (awhs) begin
                        t_aw <= cyc;
                        check("m_aw_is_write", mreq_q[0].is_wr, 1);
                        check("m_awaddr", m_axi.awaddr, mreq_q[0].addr);
                    end
                    if (whs) begin
                        check("m_w_is_write", mreq_q[0].is_wr, 1);
                        check("m_wdata", m_axi.wdata, mreq_q[0].data);
                        check("m_wstrb", m_axi.wstrb, mreq_q[0].strb);
                    end
                    if (arhs) begin
                        check("m_ar_is_read", mreq_q[0].is_wr, 0);
                        check("m_araddr", m_axi.araddr, mreq_q[0].addr);
                        void'(mreq_q.pop_front());
                    end else if ((awhs || aw_seen) && (whs || w_seen)) begin
                        void'(mreq_q.pop_front());
                        aw_seen <= 1'b0;
                        w_seen  <= 1'b0;
                    end else begin
                        if (awhs) aw_seen <= 1'b1;
                        if (whs)  w_seen  <= 1'b1;
                    end
                end
            end

            for (int p = 0; p < 2; p++) begin
                if (bvalid_s[p] || rvalid_s[p]) begin
                    check("other_port_quiet", {bvalid_s[1-p], rvalid_s[1-p], bresp_s[1-p], rresp_s[1-p]}, 0);
                    check("other_port_rdata", rdata_s[1-p], 0);
                end
                if ((bvalid_s[p] && bready_d[p]) || (rvalid_s[p] && rready_d[p])) begin
                    if (rsp_q.size() == 0) begin
                        check("rsp_pending", rsp_q.size(), 1);
                    end else begin
                        t_ret[p] <= cyc;
                        check("rsp_port", p, rsp_q[0].port);
                        check("rsp_is_write", bvalid_s[p], rsp_q[0].is_wr);
                        if (bvalid_s[p]) begin
                            check("bresp", bresp_s[p], rsp_q[0].resp);
                        end else begin
                            check("rdata", rdata_s[p], rsp_q[0].data);
                            check("rresp", rresp_s[p], rsp_q[0].resp);
                        end
                        void'(rsp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- requester tasks ----------------
    task automatic do_write(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW/8-1:0] s);
        int n = 0;
        awaddr_d[p] = a; wdata_d[p] = d; wstrb_d[p] = s;
        awvalid_d[p] = 1'b1; wvalid_d[p] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!(awready_s[p] && wready_s[p]) && n < 200);
        check("wr_grant", {awready_s[p], wready_s[p]}, 2'b11);
        check("wr_no_arready", arready_s[p], 0);
        check("wr_other_ready", {awready_s[1-p], wready_s[1-p], arready_s[1-p]}, 0);
        t_grant[p] = cyc;
        @(posedge clk);
        #1;
        awvalid_d[p] = 1'b0; wvalid_d[p] = 1'b0;
    endtask

    task automatic do_read(input int p, input logic [AW-1:0] a);
        int n = 0;
        araddr_d[p] = a;
        arvalid_d[p] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!arready_s[p] && n < 200);
        check("rd_grant", arready_s[p], 1);
        check("rd_other_ready", {awready_s[1-p], wready_s[1-p], arready_s[1-p]}, 0);
        t_grant[p] = cyc;
        @(posedge clk);
        #1;
        arvalid_d[p] = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((rsp_q.size() != 0 || mreq_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_rsp", rsp_q.size(), 0);
        check("drain_mreq", mreq_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_quiet(input string tag);
        check(tag, {s0_axi.awready, s0_axi.wready, s0_axi.arready, s0_axi.bvalid, s0_axi.rvalid,
                    s1_axi.awready, s1_axi.wready, s1_axi.arready, s1_axi.bvalid, s1_axi.rvalid,
                    m_axi.awvalid, m_axi.wvalid, m_axi.arvalid, m_axi.bready, m_axi.rready}, 0);
        check({tag, "_addr"}, m_axi.awaddr, 0);
        check({tag, "_wdata"}, m_axi.wdata, 0);
        check({tag, "_rdata"}, s0_axi.rdata | s1_axi.rdata, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int p = 0; p < 2; p++) begin
            awaddr_d[p] = '0; wdata_d[p] = '0; wstrb_d[p] = '0; araddr_d[p] = '0;
            t_grant[p] = 0; t_ret[p] = 0;
        end
        awvalid_d = '0; wvalid_d = '0; arvalid_d = '0;
        bready_d = 2'b11; rready_d = 2'b11;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_quiet("reset_state");
        @(posedge clk);
        #1 rst = 1'b0;

        // Port 0 single write, zero-wait, latency T+1 / T+3
        mreq_q.push_back(mk_req(1, 8'h10, 32'h38, 4'hF));
        rsp_q.push_back(mk_rsp(0, 1, '0, 3'd0));
        do_write(0, 8'h10, 32'h38, 4'hF);
        wait_drain();
        check("lat_master_valid", t_aw - t_grant[0], 1);
        check("lat_requester_bvalid", t_ret[0] - t_grant[0], 3);

        // Port 1 read
        rdata_m = 32'h4C; rresp_m = 3'd0;
        mreq_q.push_back(mk_req(0, 8'h18, '0, '0));
        rsp_q.push_back(mk_rsp(1, 0, 32'h4C, 3'd0));
        do_read(1, 8'h18);
        wait_drain();

        // Simultaneous writes, two rounds: expected order 0,1,0,1
        for (int r = 0; r < 2; r++) begin
            mreq_q.push_back(mk_req(1, 8'h20 + 8'(r), 32'hA0 + r, 4'hF));
            mreq_q.push_back(mk_req(1, 8'h24 + 8'(r), 32'hA1 + r, 4'h3));
            rsp_q.push_back(mk_rsp(0, 1, '0, 3'd0));
            rsp_q.push_back(mk_rsp(1, 1, '0, 3'd0));
            fork
                do_write(0, 8'h20 + 8'(r), 32'hA0 + r, 4'hF);
                do_write(1, 8'h24 + 8'(r), 32'hA1 + r, 4'h3);
            join
            wait_drain();
        end

        // Port 0 write and read together: write first
        rdata_m = 32'h5D; rresp_m = 3'd1;
        mreq_q.push_back(mk_req(1, 8'h30, 32'hB0, 4'hF));
        mreq_q.push_back(mk_req(0, 8'h34, '0, '0));
        rsp_q.push_back(mk_rsp(0, 1, '0, 3'd0));
        rsp_q.push_back(mk_rsp(0, 0, 32'h5D, 3'd1));
        fork
            do_write(0, 8'h30, 32'hB0, 4'hF);
            do_read(0, 8'h34);
        join
        wait_drain();

        // awready held off 3 cycles, wready immediate, error bresp forwarded once
        aw_stall = 3; bresp_m = 3'd2;
        aw_cyc = 0; w_cyc = 0;
        mreq_q.push_back(mk_req(1, 8'h40, 32'hC0, 4'hF));
        rsp_q.push_back(mk_rsp(0, 1, '0, 3'd2));
        do_write(0, 8'h40, 32'hC0, 4'hF);
        wait_drain();
        check("awvalid_cycles", aw_cyc, 4);
        check("wvalid_cycles", w_cyc, 1);
        aw_stall = 0; bresp_m = 3'd0;

        // Reset during R_RESP of a port-0 read; aborted read must never return
        r_hold = 1'b1;
        mreq_q.push_back(mk_req(0, 8'h50, '0, '0));
        do_read(0, 8'h50);
        begin
            int n = 0;
            while (!m_axi.rready && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("in_r_resp", m_axi.rready, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_quiet("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        r_hold = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("no_aborted_rvalid", {rvalid_s, m_axi.rready}, 0);
        end
        @(posedge clk);
        #1;
        mreq_q.push_back(mk_req(1, 8'h60, 32'hD0, 4'hF));
        mreq_q.push_back(mk_req(1, 8'h64, 32'hD1, 4'hF));
        rsp_q.push_back(mk_rsp(0, 1, '0, 3'd0));
        rsp_q.push_back(mk_rsp(1, 1, '0, 3'd0));
        fork
            do_write(0, 8'h60, 32'hD0, 4'hF);
            do_write(1, 8'h64, 32'hD1, 4'hF);
        join
        wait_drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, data bus width in bits.
REQ-002 Parameter ADDR_WIDTH, 8, address width in bits.
REQ-003 Parameter RESP_WIDTH, 3, response code width in bits.
REQ-004 axi_aclk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 axi_areset  in  1  reset, synchronous, active-high.
REQ-006 sN_axi_awaddr/awvalid in ADDR_WIDTH/1, sN_axi_awready out 1: write address from requester N (N=0,1).
REQ-007 sN_axi_wdata/wstrb/wvalid in DATA_WIDTH/DATA_WIDTH/8/1, sN_axi_wready out 1: write data from requester N.
REQ-008 sN_axi_bresp/bvalid out RESP_WIDTH/1, sN_axi_bready in 1: write response to requester N.
REQ-009 sN_axi_araddr/arvalid in ADDR_WIDTH/1, sN_axi_arready out 1: read address from requester N.
REQ-010 sN_axi_rdata/rresp/rvalid out DATA_WIDTH/RESP_WIDTH/1, sN_axi_rready in 1: read data to requester N.
REQ-011 m_axi_aw*/w*/ar* out, m_axi_bresp/bvalid/rdata/rresp/rvalid in, m_axi_awready/wready/arready in, m_axi_bready/rready out: shared AXI-Lite master port, same widths as REQ-006..010.

Function
REQ-012 Block SHALL share m_axi between requesters 0 and 1, one transaction outstanding in total.
REQ-013 Write request N = sN_axi_awvalid & sN_axi_wvalid; read request N = sN_axi_arvalid; port request N = write or read request N.
REQ-014 Arbitration SHALL be round-robin: both requesting -> port not granted last wins; one requesting -> it wins; last_grant resets to 1 (port 0 wins first tie).
REQ-015 Within granted port, write SHALL take precedence over read.
REQ-016 States: IDLE, W_ISSUE, W_RESP, W_RET, R_ISSUE, R_RESP, R_RET.
REQ-017 IDLE, grant at cycle T: sN_axi_awready+wready (write) or sN_axi_arready (read) SHALL be high combinationally in cycle T only; addr/data/strb captured into registers; last_grant<=N; next state W_ISSUE/R_ISSUE.
REQ-018 Slave-side ready outputs SHALL be low in all states except the grant cycle of REQ-017; ungranted port sees no ready.
REQ-019 W_ISSUE: m_axi_awvalid and m_axi_wvalid SHALL rise at T+1 and each SHALL drop independently the cycle after its own valid&ready handshake; both done -> W_RESP.
REQ-020 W_RESP: m_axi_bready=1; on m_axi_bvalid capture bresp -> W_RET.
REQ-021 W_RET: sN_axi_bvalid=1 with captured bresp until sN_axi_bready=1, then IDLE; new grant possible the cycle after.
REQ-022 R_ISSUE: m_axi_arvalid=1 until m_axi_arready=1 -> R_RESP.
REQ-023 R_RESP: m_axi_rready=1; on m_axi_rvalid capture rdata/rresp -> R_RET.
REQ-024 R_RET: sN_axi_rvalid=1 with captured rdata/rresp until sN_axi_rready=1, then IDLE.
REQ-025 Minimum latency, zero-wait master and requester: grant T, master valid T+1, response captured T+2, requester valid T+3, IDLE T+4.
REQ-026 Master-side outputs SHALL hold stable while valid is high and not accepted; addresses passed unmodified.
REQ-027 Requests arriving while not IDLE SHALL be left pending (ready low), never dropped.
REQ-028 Response channel outputs of non-owning port SHALL be 0.

Reset
REQ-029 axi_areset=1 at a rising edge SHALL set state IDLE, last_grant=1, all valid/ready outputs 0, captured registers 0, in the next cycle, including mid-transaction; aborted transaction SHALL not be completed after reset deasserts.

Verification
REQ-030 Port 0 write awaddr=0x10 wdata=0x38 wstrb=0xF, master all-ready, bresp=0 -> m_axi_awaddr=0x10 wdata=0x38 at T+1, s0_axi_bvalid=1 bresp=0 at T+3.
REQ-031 Port 1 read araddr=0x18, master rdata=0x4C rresp=0 -> s1_axi_rvalid=1 rdata=0x4C; s0 channels quiet.
REQ-032 Both ports request writes at same cycle after reset -> port 0 served first, port 1 next; repeated simultaneous requests alternate 0,1,0,1.
REQ-033 Port 0 asserts write and read together -> write completes first, read issued after return to IDLE.
REQ-034 m_axi_awready held low 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds with stable awaddr 3 cycles; single bresp forwarded.
REQ-035 axi_areset asserted during R_RESP -> all outputs 0 next cycle; after release, no s_rvalid for aborted read; new request granted to port 0 on tie.
